// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants and width helpers for the debounce bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int DEB_CHANNELS      = 10;
    localparam int DEB_STABLE_CYCLES = 4;
    localparam int DEB_REPEAT_CYCLES = 64;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debounce channel: two-flop synchroniser, stability
//                counter, press/release pulses and optional auto-repeat
//                (enabled by DEBOUNCE_BANK_REPEAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter int REPEAT_CYCLES = DEB_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_din,
    output logic o_dout,
    output logic o_dout_nxt,
    output logic o_rise,
    output logic o_fall,
    output logic o_rpt
);

    localparam int                 c_CNT_W    = max_int(1, clog2(STABLE_CYCLES + 1));
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    logic               r_s1;
    logic               r_s0;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dout;
    logic               r_rise;
    logic               r_fall;
    logic               w_toggle;
    logic               w_dout_nxt;

    // The counter never exceeds c_CNT_LAST, since reaching it always toggles.
    assign w_toggle   = (r_s0 != r_dout) && (r_cnt == c_CNT_LAST);
    assign w_dout_nxt = r_dout ^ w_toggle;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_s1   <= 1'b0;
            r_s0   <= 1'b0;
            r_cnt  <= '0;
            r_dout <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_din;
            r_s0   <= r_s1;
            r_dout <= w_dout_nxt;
            r_rise <= w_toggle & ~r_dout;
            r_fall <= w_toggle &  r_dout;
            if ((r_s0 == r_dout) || w_toggle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int                 c_RPT_W    = max_int(1, clog2(REPEAT_CYCLES));
    localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_rpt;

    // A release on this edge suppresses a repeat that would otherwise land on it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rpt_cnt <= '0;
            r_rpt     <= 1'b0;
        end else if (!r_dout || w_toggle) begin
            r_rpt_cnt <= '0;
            r_rpt     <= 1'b0;
        end else if (r_rpt_cnt == c_RPT_LAST) begin
            r_rpt_cnt <= '0;
            r_rpt     <= 1'b1;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
            r_rpt     <= 1'b0;
        end
    end

    assign o_rpt = r_rpt;
`else
    // Repeat period only matters when auto-repeat is built in.
    if (REPEAT_CYCLES < 2) begin : g_repeat_period_unused
    end

    assign o_rpt = 1'b0;
`endif

    assign o_dout     = r_dout;
    assign o_dout_nxt = w_dout_nxt;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : CHANNELS independent debouncers with a registered OR of all
//                debounced levels. Auto-repeat enabled by
//                DEBOUNCE_BANK_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEB_CHANNELS,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter int REPEAT_CYCLES = DEB_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt,
    output logic                any_active
);

    logic [CHANNELS-1:0] w_dout_nxt;
    logic                r_any_active;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk        (clk),
            .clr_n      (clr_n),
            .i_din      (din[i]),
            .o_dout     (dout[i]),
            .o_dout_nxt (w_dout_nxt[i]),
            .o_rise     (rise[i]),
            .o_fall     (fall[i]),
            .o_rpt      (rpt[i])
        );
    end

    // Built from next-state levels so it changes on the same edge as dout.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_any_active <= 1'b0;
        end else begin
            r_any_active <= |w_dout_nxt;
        end
    end

    assign any_active = r_any_active;

endmodule : debounce_bank
`default_nettype wire
